ldl_fifo_p4_ctrl: RTL

- Single-clock FIFO controller that owns an external 2-port RAM.
- Port A is the write port, port B is the read port; the RAM has registered read data with 1-cycle latency.
- Converts upstream valid/ready pushes into RAM writes.
- Prefetches RAM words into a 2-entry output buffer, so the downstream valid/ready interface is first-word-fall-through at full throughput.
- Sits directly upstream of the RAM in every synchronous FIFO instance.

---
 rtl/ldl_fifo_pkg.sv | 22 ++
 rtl/ldl_fifo_obuf.sv | 57 +++++
 rtl/ldl_fifo_p4_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/ldl_fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller family:
// occupancy width, full/empty compare helpers and output buffer depth.
package ldl_fifo_pkg;

    // Depth of the prefetch buffer that sits between RAM port B and the consumer.
    localparam int BUF_DEPTH = 2;

    // Occupancy counters must hold DEPTH + BUF_DEPTH words.
    function automatic int cnt_width(input int awidth);
        return awidth + 1;
    endfunction

    // Total capacity is the RAM plus the prefetch buffer.
    function automatic logic cnt_is_full(input int cnt, input int depth);
        return cnt == depth + BUF_DEPTH;
    endfunction

    function automatic logic cnt_is_empty(input int cnt);
        return cnt == 0;
    endfunction

endpackage

// File: rtl/ldl_fifo_obuf.sv
// Two-entry FIFO holding words prefetched from RAM port B.
// The head entry drives the downstream data bus directly.
module ldl_fifo_obuf
    import ldl_fifo_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    output logic [DWIDTH-1:0] rdata,
    output logic [1:0]        cnt
);

    logic [DWIDTH-1:0] mem [BUF_DEPTH];
    logic              wr_idx;
    logic              rd_idx;
    logic [1:0]        cnt_q;

    // Index and occupancy registers; a flush drops any word being captured.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (clr) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (wr) wr_idx <= ~wr_idx;
            if (rd) rd_idx <= ~rd_idx;
            cnt_q <= cnt_q + 2'(wr) - 2'(rd);
        end
    end

    // Data storage; contents are only meaningful while cnt_q says so.
    // NOTE: storage is deliberately not reset -- validity comes from cnt_q, and unreset arrays map to plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wr_idx] <= wdata;
    end

    assign rdata = mem[rd_idx];
    assign cnt   = cnt_q;

    // The read-issue rule in the parent must keep the buffer from overflowing.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(wr && !rd && !clr && cnt_q == 2'd2));

    assert property (@(posedge clk) disable iff (!rst_n)
        !(rd && !clr && cnt_q == 2'd0));

endmodule

// File: rtl/ldl_fifo_p4_ctrl.sv
// FIFO controller owning an external 2-port RAM (port A write, port B
// registered read). Prefetches into a 2-entry buffer so the output side is
// first-word-fall-through at one word per cycle.
module ldl_fifo_p4_ctrl
    import ldl_fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int AFULL  = (1 << AWIDTH) - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              ram_wea,
    output logic [AWIDTH-1:0] ram_addra,
    output logic [DWIDTH-1:0] ram_dina,
    output logic              ram_reb,
    output logic [AWIDTH-1:0] ram_addrb,
    input  logic [DWIDTH-1:0] ram_doutb,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int CW    = cnt_width(AWIDTH);

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [CW-1:0]     ram_cnt;   // words in RAM not yet read out
    logic [CW-1:0]     count_q;   // words held anywhere in the FIFO
    logic              rd_pend;   // RAM read data arrives this cycle
    logic [1:0]        buf_cnt;
    logic [2:0]        pipe_occ;  // buffer slots claimed after this cycle's pop
    logic              push;
    logic              pop;
    logic              issue;

    // Status flags come from registered occupancy only.
    assign full        = cnt_is_full(int'(count_q), DEPTH);
    assign empty       = cnt_is_empty(int'(count_q));
    assign almost_full = int'(count_q) >= AFULL;
    assign in_ready    = !full;
    assign count       = count_q;
    assign out_valid   = buf_cnt != 2'd0;

    // A flush cycle discards both handshakes.
    assign push = in_valid & in_ready & ~clr;
    assign pop  = out_valid & out_ready & ~clr;

    // Read ahead while a buffer slot is free, counting this cycle's pop as
    // freeing one; only words committed at an earlier edge are eligible.
    assign pipe_occ = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue    = (ram_cnt != '0) & ~clr & (pipe_occ < 3'(BUF_DEPTH));

    assign ram_wea   = push;
    assign ram_addra = wptr;
    assign ram_dina  = in_data;
    assign ram_reb   = issue;
    assign ram_addrb = rptr;

    // Pointers, occupancy counters and the read-pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            count_q <= '0;
            rd_pend <= 1'b0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            count_q <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push)  wptr <= wptr + AWIDTH'(1);
            if (issue) rptr <= rptr + AWIDTH'(1);
            rd_pend <= issue;
            ram_cnt <= ram_cnt + CW'(push) - CW'(issue);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    ldl_fifo_obuf #(
        .DWIDTH (DWIDTH)
    ) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .wr    (rd_pend),
        .wdata (ram_doutb),
        .rd    (pop),
        .rdata (out_data),
        .cnt   (buf_cnt)
    );

    // RAM-side occupancy can never exceed the RAM itself.
    assert property (@(posedge clk) disable iff (!rst_n)
        ram_cnt <= CW'(DEPTH));

    // A read and a write never target the same RAM word in one cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && issue && wptr == rptr));

endmodule
